interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_SRC, default 4: number of interrupt sources; source 0 is the timer interrupt.
REQ-002 Parameter ID_W, default 2: width of irq_id, equal to clog2(NUM_SRC).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 src_pulse  input  NUM_SRC  one-cycle event pulses from peripherals; bit 0 is the timer interrupt pulse.
REQ-006 global_en  input  1  CPU global interrupt enable.
REQ-007 mask_we  input  1  write strobe for mask register.
REQ-008 mask_wdata  input  NUM_SRC  new mask value; 1 means enabled.
REQ-009 mask  output  NUM_SRC  current mask register.
REQ-010 pending  output  NUM_SRC  latched pending events.
REQ-011 irq  output  1  registered interrupt request to the CPU.
REQ-012 irq_id  output  ID_W  index of the requested source; valid while irq=1.
REQ-013 irq_ack  input  1  one-cycle CPU acknowledge of the request.
REQ-014 eoi  input  1  one-cycle CPU end-of-interrupt.

Function
REQ-015 pending[i] shall set on the cycle after src_pulse[i]=1, regardless of mask[i]; repeated pulses while set shall coalesce.
REQ-016 Request eligibility shall be pending & mask; the lowest eligible index shall win.
REQ-017 FSM states shall be IDLE, REQ and SERVICE.
REQ-018 IDLE: if global_en=1 and any source is eligible, the block shall go to REQ, set irq=1 and load irq_id with the winner in the same edge.
REQ-019 Latency shall be: src_pulse at edge N, pending at N+1, irq at N+2, when in IDLE with mask and global_en set.
REQ-020 REQ: irq_id shall hold stable; a newly eligible higher-priority source shall not replace it.
REQ-021 REQ with irq_ack=1: the block shall clear pending[irq_id], clear irq and enter SERVICE at the next edge.
REQ-022 REQ with global_en=0 and no irq_ack: the block shall withdraw, setting irq=0 and returning to IDLE with pending unchanged.
REQ-023 REQ: mask changes shall not withdraw the request.
REQ-024 Simultaneous irq_ack and global_en=0 in REQ: irq_ack shall win.
REQ-025 SERVICE: no nesting; irq shall stay 0; eoi=1 shall return the block to IDLE.
REQ-026 The next arbitration shall occur no earlier than the first cycle in IDLE, giving a minimum of one cycle with irq=0 between requests.
REQ-027 irq_ack outside REQ and eoi outside SERVICE shall be ignored.
REQ-028 src_pulse[i] in the same cycle as the clear of pending[i] shall leave pending[i]=1; a set shall win over a clear.
REQ-029 A mask write shall take effect at the next edge; mask_wdata bits beyond NUM_SRC do not exist.

Reset
REQ-030 rst=1 shall force state=IDLE, mask=0, pending=0, irq=0 and irq_id=0 at the next edge.
REQ-031 rst shall override every other input in the same cycle, including src_pulse, mask_we, irq_ack and eoi.
REQ-032 rst asserted in REQ or SERVICE shall drop irq and discard all pending events.

Structure
REQ-033 A shared package shall hold the FSM state encoding (IDLE=0, REQ=1, SERVICE=2, 2 bits), the default NUM_SRC, and the source index constant IRQ_SRC_TIMER=0.
REQ-034 One combinational sub-module, irq_prio_enc, shall perform lowest-index-wins encoding with a valid flag; everything else is in interrupt_controller.

Verification
REQ-035 Scenario 1: mask=0001, global_en=1, src_pulse=0001 at edge 10 -> pending[0]=1 at edge 11, irq=1 and irq_id=0 at edge 12; irq_ack at 14 -> irq=0, pending=0 and state SERVICE at 15; eoi at 17 -> IDLE at 18.
REQ-036 Scenario 2: mask=1111, pulses on sources 3 and 1 in the same cycle -> irq_id=1; ack then eoi -> second request with irq_id=3.
REQ-037 Scenario 3: mask=0000 and src_pulse=0100 -> pending=0100 and irq stays 0; write mask=0100 -> irq=1 and irq_id=2 two edges after the write.
REQ-038 Scenario 4: in REQ with irq_id=2, pulse source 0 -> irq_id stays 2; then drop global_en -> irq=0, pending=0101; raise global_en -> irq_id=0.
REQ-039 Scenario 5: src_pulse[1] in the same cycle as irq_ack for irq_id=1 -> pending[1] remains 1; source 1 is requested again after eoi.
REQ-040 Scenario 6: rst asserted in SERVICE together with src_pulse=1111 -> all outputs 0 and state IDLE at the next edge; no irq afterwards without new pulses.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared state encoding and source constants for the interrupt controller
package interrupt_controller_pkg;

    localparam int DEFAULT_NUM_SRC = 4;
    localparam int IRQ_SRC_TIMER   = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-wins priority encoder with valid flag
module irq_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    output logic [ID_W-1:0] id,
    output logic            valid
);

    // Scan from the top so the lowest set index is the last assignment.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - pending/mask registers and IDLE/REQ/SERVICE request FSM
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SRC = DEFAULT_NUM_SRC,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_pulse,
    input  logic               global_en,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic [NUM_SRC-1:0] mask,
    output logic [NUM_SRC-1:0] pending,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               eoi
);

    irq_state_t         state;
    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    win_id;
    logic               win_valid;
    logic               ack_now;
    logic [NUM_SRC-1:0] clr_vec;

    assign eligible = pending & mask;
    assign ack_now  = (state == ST_REQ) && irq_ack;

    irq_prio_enc #(
        .N    (NUM_SRC),
        .ID_W (ID_W)
    ) u_prio (
        .req   (eligible),
        .id    (win_id),
        .valid (win_valid)
    );

    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_vec[i] = ack_now && (irq_id == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mask    <= '0;
            pending <= '0;
            irq     <= 1'b0;
            irq_id  <= '0;
        end else begin
            if (mask_we) begin
                mask <= mask_wdata;
            end
            // A fresh pulse on the acknowledged source survives its clear.
            pending <= (pending & ~clr_vec) | src_pulse;

            case (state)
                ST_IDLE: begin
                    if (global_en && win_valid) begin
                        state  <= ST_REQ;
                        irq    <= 1'b1;
                        irq_id <= win_id;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        state <= ST_SERVICE;
                        irq   <= 1'b0;
                    end else if (!global_en) begin
                        state <= ST_IDLE;
                        irq   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed scenarios plus randomized run against a behavioural model
module tb_interrupt_controller;

    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] src_pulse;
    logic          global_en;
    logic          mask_we;
    logic [NS-1:0] mask_wdata;
    logic [NS-1:0] mask;
    logic [NS-1:0] pending;
    logic          irq;
    logic [1:0]    irq_id;
    logic          irq_ack;
    logic          eoi;

    int passed = 0;
    int total  = 0;

    // Behavioural model: a request is either being offered, being serviced, or neither.
    bit [NS-1:0] m_mask;
    bit [NS-1:0] m_pend;
    bit          m_irq;
    bit [1:0]    m_id;
    bit          m_busy;

    always #5 clk = ~clk;

    interrupt_controller #(.NUM_SRC(NS), .ID_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_pulse  (src_pulse),
        .global_en  (global_en),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .irq        (irq),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .eoi        (eoi)
    );

    task automatic model_step();
        bit [NS-1:0] nxt;
        if (rst) begin
            m_mask = '0; m_pend = '0; m_irq = 0; m_id = '0; m_busy = 0;
        end else begin
            nxt = m_pend;
            if (m_irq && irq_ack) nxt[m_id] = 1'b0;
            nxt = nxt | src_pulse;
            if (m_irq) begin
                if (irq_ack) begin
                    m_irq = 0; m_busy = 1;
                end else if (!global_en) begin
                    m_irq = 0;
                end
            end else if (m_busy) begin
                if (eoi) m_busy = 0;
            end else if (global_en) begin
                for (int i = 0; i < NS; i++) begin
                    if (!m_irq && m_pend[i] && m_mask[i]) begin
                        m_irq = 1; m_id = 2'(i);
                    end
                end
            end
            m_pend = nxt;
            if (mask_we) m_mask = mask_wdata;
        end
    endtask

    // One clock: model follows the edge, strobes are cleared, outputs settle by negedge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        src_pulse = '0; mask_we = 0; irq_ack = 0; eoi = 0;
    endtask

    task automatic test_reset();
        rst = 1; global_en = 1; src_pulse = 4'b1111; mask_we = 1; mask_wdata = 4'b1111;
        irq_ack = 1; eoi = 1;
        cyc(); cyc();
        total++; if ({mask, pending} !== 8'h00) $display("FAIL reset_regs: got %h want 00", {mask, pending}); else passed++;
        total++; if ({irq, irq_id} !== 3'b000) $display("FAIL reset_irq: got %b want 000", {irq, irq_id}); else passed++;
        rst = 0;
    endtask

    task automatic test_single_timer();
        mask_we = 1; mask_wdata = 4'b0001; global_en = 1;
        cyc();
        total++; if (mask !== 4'b0001) $display("FAIL s1_mask: got %b want 0001", mask); else passed++;
        src_pulse = 4'b0001;
        cyc();
        total++; if (pending !== 4'b0001 || irq !== 1'b0) $display("FAIL s1_pend: got %b/%b want 0001/0", pending, irq); else passed++;
        cyc();
        total++; if (irq !== 1'b1 || irq_id !== 2'd0) $display("FAIL s1_irq: got %b/%0d want 1/0", irq, irq_id); else passed++;
        cyc();
        irq_ack = 1;
        cyc();
        total++; if (irq !== 1'b0 || pending !== 4'b0000) $display("FAIL s1_ack: got %b/%b want 0/0000", irq, pending); else passed++;
        src_pulse = 4'b0001;
        cyc(); cyc();
        total++; if (irq !== 1'b0) $display("FAIL s1_no_nest: got %b want 0", irq); else passed++;
        eoi = 1;
        cyc(); cyc();
        total++; if (irq !== 1'b1 || irq_id !== 2'd0) $display("FAIL s1_after_eoi: got %b/%0d want 1/0", irq, irq_id); else passed++;
        irq_ack = 1; cyc(); eoi = 1; cyc();
    endtask

    task automatic test_priority();
        mask_we = 1; mask_wdata = 4'b1111; cyc();
        src_pulse = 4'b1010; cyc(); cyc();
        total++; if (irq !== 1'b1 || irq_id !== 2'd1) $display("FAIL s2_first: got %b/%0d want 1/1", irq, irq_id); else passed++;
        irq_ack = 1; cyc();
        total++; if (pending !== 4'b1000) $display("FAIL s2_pend: got %b want 1000", pending); else passed++;
        eoi = 1; cyc();
        total++; if (irq !== 1'b0) $display("FAIL s2_gap: got %b want 0", irq); else passed++;
        cyc();
        total++; if (irq !== 1'b1 || irq_id !== 2'd3) $display("FAIL s2_second: got %b/%0d want 1/3", irq, irq_id); else passed++;
        irq_ack = 1; cyc(); eoi = 1; cyc();
    endtask

    task automatic test_mask_and_withdraw();
        rst = 1; cyc(); rst = 0; global_en = 1;
        src_pulse = 4'b0100; cyc(); cyc();
        total++; if (pending !== 4'b0100 || irq !== 1'b0) $display("FAIL s3_masked: got %b/%b want 0100/0", pending, irq); else passed++;
        mask_we = 1; mask_wdata = 4'b0100; cyc();
        total++; if (irq !== 1'b0) $display("FAIL s3_one_edge: got %b want 0", irq); else passed++;
        cyc();
        total++; if (irq !== 1'b1 || irq_id !== 2'd2) $display("FAIL s3_irq: got %b/%0d want 1/2", irq, irq_id); else passed++;
        mask_we = 1; mask_wdata = 4'b1111; src_pulse = 4'b0001; cyc(); cyc();
        total++; if (irq !== 1'b1 || irq_id !== 2'd2) $display("FAIL s4_stable: got %b/%0d want 1/2", irq, irq_id); else passed++;
        mask_we = 1; mask_wdata = 4'b0000; cyc();
        total++; if (irq !== 1'b1) $display("FAIL s4_mask_hold: got %b want 1", irq); else passed++;
        mask_we = 1; mask_wdata = 4'b1111; global_en = 0; cyc();
        total++; if (irq !== 1'b0 || pending !== 4'b0101) $display("FAIL s4_withdraw: got %b/%b want 0/0101", irq, pending); else passed++;
        global_en = 1; cyc();
        total++; if (irq !== 1'b1 || irq_id !== 2'd0) $display("FAIL s4_rearb: got %b/%0d want 1/0", irq, irq_id); else passed++;
        irq_ack = 1; cyc(); eoi = 1; cyc(); cyc();
        total++; if (irq !== 1'b1 || irq_id !== 2'd2) $display("FAIL s4_next: got %b/%0d want 1/2", irq, irq_id); else passed++;
        irq_ack = 1; global_en = 0; cyc();
        total++; if (irq !== 1'b0 || pending !== 4'b0000) $display("FAIL s4_ack_wins: got %b/%b want 0/0000", irq, pending); else passed++;
        global_en = 1; eoi = 1; cyc();
    endtask

    task automatic test_set_beats_clear();
        rst = 1; cyc(); rst = 0; global_en = 1;
        mask_we = 1; mask_wdata = 4'b0010; src_pulse = 4'b0010; cyc(); cyc();
        total++; if (irq !== 1'b1 || irq_id !== 2'd1) $display("FAIL s5_irq: got %b/%0d want 1/1", irq, irq_id); else passed++;
        irq_ack = 1; src_pulse = 4'b0010; cyc();
        total++; if (pending !== 4'b0010 || irq !== 1'b0) $display("FAIL s5_keep: got %b/%b want 0010/0", pending, irq); else passed++;
        eoi = 1; cyc(); cyc();
        total++; if (irq !== 1'b1 || irq_id !== 2'd1) $display("FAIL s5_again: got %b/%0d want 1/1", irq, irq_id); else passed++;
        irq_ack = 1; cyc(); eoi = 1; cyc();
    endtask

    task automatic test_reset_in_service();
        mask_we = 1; mask_wdata = 4'b1111; src_pulse = 4'b0001; cyc(); cyc();
        irq_ack = 1; cyc();
        rst = 1; src_pulse = 4'b1111; eoi = 1; mask_we = 1; mask_wdata = 4'b1111; cyc();
        total++; if ({mask, pending, irq, irq_id} !== 11'd0) $display("FAIL s6_reset: got %h want 000", {mask, pending, irq, irq_id}); else passed++;
        rst = 0; global_en = 1; mask_we = 1; mask_wdata = 4'b1111; cyc(); cyc(); cyc();
        total++; if (irq !== 1'b0 || pending !== 4'b0000) $display("FAIL s6_quiet: got %b/%b want 0/0000", irq, pending); else passed++;
    endtask

    task automatic test_random();
        rst = 1; cyc(); rst = 0;
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 59) == 0);
            src_pulse  = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
            global_en  = ($urandom_range(0, 7) != 0);
            mask_we    = ($urandom_range(0, 7) == 0);
            mask_wdata = NS'($urandom);
            irq_ack    = ($urandom_range(0, 2) == 0);
            eoi        = ($urandom_range(0, 2) == 0);
            cyc();
            total++; if (mask !== m_mask) $display("FAIL rnd_mask @%0d: got %b want %b", n, mask, m_mask); else passed++;
            total++; if (pending !== m_pend) $display("FAIL rnd_pending @%0d: got %b want %b", n, pending, m_pend); else passed++;
            total++; if (irq !== m_irq) $display("FAIL rnd_irq @%0d: got %b want %b", n, irq, m_irq); else passed++;
            if (m_irq) begin
                total++; if (irq_id !== m_id) $display("FAIL rnd_irq_id @%0d: got %0d want %0d", n, irq_id, m_id); else passed++;
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; src_pulse = '0; global_en = 0; mask_we = 0; mask_wdata = '0; irq_ack = 0; eoi = 0;
        @(negedge clk);
        test_reset();
        test_single_timer();
        test_priority();
        test_mask_and_withdraw();
        test_set_beats_clear();
        test_reset_in_service();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
